// File: rtl/fpu_pkg.sv
// Shared types and constants for the FPU issue/sequencing logic.
package fpu_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    WAIT  = 3'd2,
    WB    = 3'd3,
    DRAIN = 3'd4
  } fpu_ctrl_state_e;

  localparam logic [3:0] FPU_OP_NOP    = 4'h0;
  localparam logic [3:0] FPU_OP_FADD   = 4'h1;
  localparam logic [3:0] FPU_OP_FSUB   = 4'h2;
  localparam logic [3:0] FPU_OP_FMUL   = 4'h3;
  localparam logic [3:0] FPU_OP_FDIV   = 4'h4;
  localparam logic [3:0] FPU_OP_FSQRT  = 4'h5;
  localparam logic [3:0] FPU_OP_FMADD  = 4'h6;
  localparam logic [3:0] FPU_OP_FMSUB  = 4'h7;
  localparam logic [3:0] FPU_OP_FNMADD = 4'h8;
  localparam logic [3:0] FPU_OP_FNMSUB = 4'h9;
  localparam logic [3:0] FPU_OP_FMIN   = 4'hA;
  localparam logic [3:0] FPU_OP_FMAX   = 4'hB;
  localparam logic [3:0] FPU_OP_FCVT   = 4'hC;
  localparam logic [3:0] FPU_OP_FCMP   = 4'hD;
  localparam logic [3:0] FPU_OP_FSGNJ  = 4'hE;

  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;
  localparam logic [2:0] RM_DYN = 3'b111;

endpackage

// File: rtl/fpu_timeout_cnt.sv
// Clear/enable cycle counter with a terminal-count flag at TIMEOUT_CYCLES-1.
module fpu_timeout_cnt #(
  parameter int CNT_W          = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tc_o = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Saturates at terminal count so a stuck enable can never wrap back to zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !tc_o) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Issues one FP instruction to the FPU, stalls the pipeline while it runs and
// returns a single registered writeback beat; handles flush and FPU timeout.
module fpu_issue_ctrl
  import fpu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        issue_valid_i,
  input  logic [3:0]  issue_op_i,
  input  logic [31:0] issue_rs1_i,
  input  logic [31:0] issue_rs2_i,
  input  logic [31:0] issue_rs3_i,
  input  logic [4:0]  issue_rd_i,
  input  logic        issue_fp_we_i,
  input  logic        flush_i,
  output logic        fpu_start_o,
  output logic [3:0]  fpu_op_o,
  output logic [31:0] fpu_inp1_o,
  output logic [31:0] fpu_inp2_o,
  output logic [31:0] fpu_inp3_o,
  output logic        fpu_fp_we_o,
  input  logic        fpu_busy_i,
  input  logic        fpu_done_i,
  input  logic [31:0] fpu_result_i,
  output logic        stall_o,
  output logic        wb_valid_o,
  output logic [4:0]  wb_rd_o,
  output logic [31:0] wb_data_o,
  output logic        wb_fp_we_o,
  output logic        timeout_err_o
);

  fpu_ctrl_state_e state_q, state_d;
  logic [3:0]  op_q, op_d;
  logic [31:0] rs1_q, rs1_d;
  logic [31:0] rs2_q, rs2_d;
  logic [31:0] rs3_q, rs3_d;
  logic [4:0]  rd_q, rd_d;
  logic        fp_we_q, fp_we_d;
  logic [31:0] wb_data_q, wb_data_d;

  logic cnt_clr;
  logic cnt_en;
  logic cnt_tc;
  logic stall;
  logic start;
  logic timeout_err;

  // BusyF carries no sequencing information for this controller.
  logic unused_busy;
  assign unused_busy = fpu_busy_i;

  fpu_timeout_cnt #(
    .CNT_W          (CNT_W),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (cnt_clr),
    .en_i  (cnt_en),
    .tc_o  (cnt_tc)
  );

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    rs3_d       = rs3_q;
    rd_d        = rd_q;
    fp_we_d     = fp_we_q;
    wb_data_d   = wb_data_q;
    stall       = 1'b0;
    start       = 1'b0;
    timeout_err = 1'b0;
    cnt_clr     = 1'b0;
    cnt_en      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (issue_valid_i && !flush_i) begin
          op_d    = issue_op_i;
          rs1_d   = issue_rs1_i;
          rs2_d   = issue_rs2_i;
          rs3_d   = issue_rs3_i;
          rd_d    = issue_rd_i;
          fp_we_d = issue_fp_we_i;
          stall   = 1'b1;
          state_d = START;
        end
      end
      START: begin
        // The start pulse goes out even on flush: the FPU is already committed.
        start   = 1'b1;
        stall   = 1'b1;
        cnt_clr = 1'b1;
        state_d = flush_i ? DRAIN : WAIT;
      end
      WAIT: begin
        stall  = 1'b1;
        cnt_en = 1'b1;
        if (flush_i) begin
          if (fpu_done_i) begin
            state_d = IDLE;
          end else begin
            cnt_clr = 1'b1;
            state_d = DRAIN;
          end
        end else if (fpu_done_i) begin
          wb_data_d = fpu_result_i;
          state_d   = WB;
        end else if (cnt_tc) begin
          timeout_err = 1'b1;
          cnt_clr     = 1'b1;
          state_d     = DRAIN;
        end
      end
      WB: begin
        state_d = IDLE;
      end
      DRAIN: begin
        // Only a new FP issue is held back while the abandoned op drains.
        stall  = issue_valid_i;
        cnt_en = 1'b1;
        if (fpu_done_i || cnt_tc) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      op_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rs3_q     <= '0;
      rd_q      <= '0;
      fp_we_q   <= 1'b0;
      wb_data_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      rs3_q     <= rs3_d;
      rd_q      <= rd_d;
      fp_we_q   <= fp_we_d;
      wb_data_q <= wb_data_d;
    end
  end

  assign fpu_start_o   = start;
  assign fpu_op_o      = op_q;
  assign fpu_inp1_o    = rs1_q;
  assign fpu_inp2_o    = rs2_q;
  assign fpu_inp3_o    = rs3_q;
  assign fpu_fp_we_o   = fp_we_q;
  assign stall_o       = stall;
  assign wb_valid_o    = (state_q == WB);
  assign wb_rd_o       = rd_q;
  assign wb_data_o     = wb_data_q;
  assign wb_fp_we_o    = (state_q == WB) & fp_we_q;
  assign timeout_err_o = timeout_err;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Directed self-checking bench for fpu_issue_ctrl with a hand-driven FPU.
module tb_fpu_issue_ctrl;
  import fpu_pkg::*;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        issue_valid = 1'b0;
  logic [3:0]  issue_op = '0;
  logic [31:0] issue_rs1 = '0;
  logic [31:0] issue_rs2 = '0;
  logic [31:0] issue_rs3 = '0;
  logic [4:0]  issue_rd = '0;
  logic        issue_fp_we = 1'b0;
  logic        flush = 1'b0;
  logic        fpu_busy = 1'b0;
  logic        fpu_done = 1'b0;
  logic [31:0] fpu_result = '0;

  logic        fpu_start;
  logic [3:0]  fpu_op;
  logic [31:0] fpu_inp1, fpu_inp2, fpu_inp3;
  logic        fpu_fp_we;
  logic        stall;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_fp_we;
  logic        timeout_err;

  int n_chk  = 0;
  int n_fail = 0;

  fpu_issue_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .issue_valid_i (issue_valid),
    .issue_op_i    (issue_op),
    .issue_rs1_i   (issue_rs1),
    .issue_rs2_i   (issue_rs2),
    .issue_rs3_i   (issue_rs3),
    .issue_rd_i    (issue_rd),
    .issue_fp_we_i (issue_fp_we),
    .flush_i       (flush),
    .fpu_start_o   (fpu_start),
    .fpu_op_o      (fpu_op),
    .fpu_inp1_o    (fpu_inp1),
    .fpu_inp2_o    (fpu_inp2),
    .fpu_inp3_o    (fpu_inp3),
    .fpu_fp_we_o   (fpu_fp_we),
    .fpu_busy_i    (fpu_busy),
    .fpu_done_i    (fpu_done),
    .fpu_result_i  (fpu_result),
    .stall_o       (stall),
    .wb_valid_o    (wb_valid),
    .wb_rd_o       (wb_rd),
    .wb_data_o     (wb_data),
    .wb_fp_we_o    (wb_fp_we),
    .timeout_err_o (timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of test, expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // Caller is just past a rising edge with the controller in IDLE.
  task automatic run_op(input logic [4:0] rd, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] c, input logic we,
                        input int n, input logic [31:0] res);
    int stall_cnt;
    int start_cnt;
    int wbv_cnt;
    stall_cnt = 0;
    start_cnt = 0;
    wbv_cnt   = 0;
    issue_valid = 1'b1;
    issue_op    = op;
    issue_rs1   = a;
    issue_rs2   = b;
    issue_rs3   = c;
    issue_rd    = rd;
    issue_fp_we = we;
    mid();
    chk("issue_stall", stall, 1);
    chk("issue_no_start", fpu_start, 0);
    chk("issue_no_wb", wb_valid, 0);
    stall_cnt += int'(stall);
    start_cnt += int'(fpu_start);
    nxt();
    mid();
    chk("start_pulse", fpu_start, 1);
    chk("start_op", fpu_op, op);
    chk("start_inp1", fpu_inp1, a);
    chk("start_inp2", fpu_inp2, b);
    chk("start_inp3", fpu_inp3, c);
    chk("start_fp_we", fpu_fp_we, we);
    stall_cnt += int'(stall);
    start_cnt += int'(fpu_start);
    for (int k = 1; k <= n; k++) begin
      nxt();
      fpu_done   = (k == n);
      fpu_result = (k == n) ? res : (32'hBAD0_0000 ^ k);
      mid();
      stall_cnt += int'(stall);
      start_cnt += int'(fpu_start);
      wbv_cnt   += int'(wb_valid);
    end
    nxt();
    fpu_done   = 1'b0;
    fpu_result = 32'h0;
    mid();
    chk("wb_valid", wb_valid, 1);
    chk("wb_rd", wb_rd, rd);
    chk("wb_data", wb_data, res);
    chk("wb_fp_we", wb_fp_we, we);
    chk("wb_stall_released", stall, 0);
    chk("wb_no_start", fpu_start, 0);
    chk("stall_cycles", stall_cnt, n + 2);
    chk("start_cycles", start_cnt, 1);
    chk("early_wb", wbv_cnt, 0);
  endtask

  initial begin
    int to_cnt;
    int to_at;
    int st_cnt;

    // Reset state
    mid();
    chk("rst_start", fpu_start, 0);
    chk("rst_stall", stall, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_op", fpu_op, 0);
    chk("rst_timeout", timeout_err, 0);
    rst_n = 1'b1;

    // Single FADD, result after 8 WAIT cycles
    nxt();
    run_op(5'd5, FPU_OP_FADD, 32'h3F80_0000, 32'h4000_0000, 32'h0, 1'b1, 8, 32'h4040_0000);

    // Back-to-back issues: second one presented in the cycle right after WB
    nxt();
    run_op(5'd3, FPU_OP_FMUL, 32'h4000_0000, 32'h4040_0000, 32'h0, 1'b1, 2, 32'h40C0_0000);
    nxt();
    run_op(5'd4, FPU_OP_FMADD, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 1'b0, 3, 32'h4000_0000);
    nxt();
    issue_valid = 1'b0;
    mid();
    chk("idle_no_wb", wb_valid, 0);
    chk("idle_wb_data_hold", wb_data, 32'h4000_0000);
    chk("idle_no_stall", stall, 0);

    // Flush in the 3rd WAIT cycle
    nxt();
    issue_valid = 1'b1;
    issue_rd    = 5'd6;
    issue_op    = FPU_OP_FDIV;
    issue_fp_we = 1'b1;
    mid();
    chk("fl_issue_stall", stall, 1);
    nxt();
    mid();
    chk("fl_start", fpu_start, 1);
    nxt();
    nxt();
    nxt();
    issue_valid = 1'b0;
    flush       = 1'b1;
    mid();
    chk("fl_wait_stall", stall, 1);
    nxt();
    flush = 1'b0;
    mid();
    chk("drain_stall_free", stall, 0);
    chk("drain_no_start", fpu_start, 0);
    nxt();
    issue_valid = 1'b1;
    issue_rd    = 5'd7;
    mid();
    chk("drain_blocks_issue", stall, 1);
    nxt();
    issue_valid = 1'b0;
    fpu_done    = 1'b1;
    fpu_result  = 32'hDEAD_BEEF;
    mid();
    chk("drain_done_no_wb", wb_valid, 0);
    chk("drain_done_stall", stall, 0);
    nxt();
    fpu_done = 1'b0;
    mid();
    chk("drain_exit_no_wb", wb_valid, 0);
    chk("drain_discard_data", wb_data, 32'h4000_0000);

    // Timeout: FPU never answers
    nxt();
    issue_valid = 1'b1;
    issue_rd    = 5'd8;
    issue_op    = FPU_OP_FSQRT;
    mid();
    chk("to_issue_stall", stall, 1);
    nxt();
    issue_valid = 1'b0;
    mid();
    chk("to_start", fpu_start, 1);
    to_cnt = 0;
    to_at  = 0;
    for (int k = 1; k <= TO; k++) begin
      nxt();
      mid();
      if (timeout_err) begin
        to_cnt++;
        to_at = k;
      end
    end
    chk("timeout_pulses", to_cnt, 1);
    chk("timeout_cycle", to_at, TO);
    to_cnt = 0;
    st_cnt = 0;
    for (int k = 1; k <= TO; k++) begin
      nxt();
      mid();
      to_cnt += int'(timeout_err);
      st_cnt += int'(stall);
    end
    chk("drain_second_timeout_silent", to_cnt, 0);
    chk("drain_stall_released", st_cnt, 0);
    chk("drain_timeout_no_wb", wb_valid, 0);
    // Second timeout must have forced IDLE, so this issue starts normally
    nxt();
    run_op(5'd9, FPU_OP_FSUB, 32'h4100_0000, 32'h3F80_0000, 32'h0, 1'b1, 3, 32'h40E0_0000);

    // Done and flush together in WAIT: flush wins, next cycle is IDLE
    nxt();
    issue_valid = 1'b1;
    issue_rd    = 5'd10;
    mid();
    chk("df_issue_stall", stall, 1);
    nxt();
    mid();
    chk("df_start", fpu_start, 1);
    nxt();
    nxt();
    issue_valid = 1'b0;
    fpu_done    = 1'b1;
    flush       = 1'b1;
    fpu_result  = 32'h1234_5678;
    mid();
    chk("df_no_wb", wb_valid, 0);
    nxt();
    fpu_done = 1'b0;
    flush    = 1'b0;
    run_op(5'd11, FPU_OP_FMAX, 32'h3F80_0000, 32'h4000_0000, 32'h0, 1'b1, 1, 32'h4000_0001);

    // Asynchronous reset in the middle of WAIT
    nxt();
    issue_valid = 1'b1;
    issue_rd    = 5'd12;
    issue_op    = FPU_OP_FCVT;
    issue_rs1   = 32'hCAFE_F00D;
    mid();
    chk("rw_issue_stall", stall, 1);
    nxt();
    issue_valid = 1'b0;
    nxt();
    nxt();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_start", fpu_start, 0);
    chk("arst_stall", stall, 0);
    chk("arst_wb_valid", wb_valid, 0);
    chk("arst_wb_data", wb_data, 0);
    chk("arst_wb_rd", wb_rd, 0);
    chk("arst_op", fpu_op, 0);
    chk("arst_inp1", fpu_inp1, 0);
    chk("arst_fp_we", fpu_fp_we, 0);
    chk("arst_timeout", timeout_err, 0);
    mid();
    rst_n = 1'b1;
    nxt();
    run_op(5'd13, FPU_OP_FADD, 32'h4040_0000, 32'h3F80_0000, 32'h0, 1'b1, 4, 32'h4080_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fpu_issue_ctrl.md
Name: fpu_issue_ctrl

Overview:
- Sequences the single-precision FPU for the pipelined core.
- Accepts one decoded FP instruction from the ID/EX stage, latches its operands, and drives the FPU StartF/BusyF/DoneF handshake.
- Stalls the pipeline while the operation runs, then presents one registered writeback beat to the FP register file.
- Handles pipeline flushes and an FPU that never answers (timeout).

Parameters:
- TIMEOUT_CYCLES, 64: WAIT-state cycles allowed before the op is abandoned; must be ≥ 2 and < 2**CNT_W.
- CNT_W, 8: width of the timeout counter.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- issue_valid_i  in  1  ID/EX holds an FP instruction
- issue_op_i  in  4  FPU opcode
- issue_rs1_i / issue_rs2_i / issue_rs3_i  in  32 each  source operands
- issue_rd_i  in  5  FP destination register
- issue_fp_we_i  in  1  instruction writes the FP register file
- flush_i  in  1  pipeline flush; squashes the in-flight FP instruction
- fpu_start_o  out  1  StartF to the FPU
- fpu_op_o  out  4  latched opcode
- fpu_inp1_o / fpu_inp2_o / fpu_inp3_o  out  32 each  latched operands
- fpu_fp_we_o  out  1  latched fp_we to the FPU
- fpu_busy_i  in  1  BusyF
- fpu_done_i  in  1  DoneF, one-cycle pulse
- fpu_result_i  in  32  FPU result, valid with fpu_done_i
- stall_o  out  1  freeze IF/ID/EX
- wb_valid_o  out  1  writeback beat
- wb_rd_o  out  5  destination register
- wb_data_o  out  32  result
- wb_fp_we_o  out  1  FP register file write enable, equal to wb_valid_o & latched fp_we
- timeout_err_o  out  1  one-cycle pulse on timeout

Behaviour:
- Reset: every output 0, state IDLE, counter 0, all latches 0. Reset asserted mid-operation returns to IDLE immediately; the FPU is reset by the same rst_n.
- IDLE:
  - issue_valid_i & !flush_i: latch op, operands, rd and fp_we; assert stall_o combinationally in this cycle; go to START.
  - issue_valid_i & flush_i: ignore the issue.
- START: fpu_start_o = 1 for exactly one cycle; stall_o = 1; counter cleared; go to WAIT.
- WAIT: stall_o = 1; counter increments each cycle.
  - fpu_done_i: register fpu_result_i into wb_data_o; go to WB.
  - Counter reaches TIMEOUT_CYCLES−1 without done: pulse timeout_err_o; go to DRAIN.
  - fpu_busy_i is informational only and does not gate transitions.
- WB: wb_valid_o = 1 for one cycle with wb_rd_o/wb_data_o; stall_o = 0, so the pipeline advances in the same cycle; go to IDLE. No new issue is accepted in WB.
- DRAIN (flush or timeout with the FPU still working):
  - stall_o = issue_valid_i, so a new FP instruction is blocked but other instructions flow.
  - On fpu_done_i the result is discarded; go to IDLE.
  - A second timeout in DRAIN forces IDLE without a further error pulse.
- Flush:
  - In START: fpu_start_o is still driven this cycle (the FPU is already committed); go to DRAIN.
  - In WAIT: go to DRAIN, no writeback.
  - In WAIT with fpu_done_i in the same cycle: flush wins; result discarded; go to IDLE.
  - In WB: writeback still completes (the instruction has already committed).
- Latency, issue to wb_valid_o: 2 + N cycles, where N is the number of WAIT cycles until DoneF.
- Throughput: one FP op in flight; back-to-back issues are separated by at least one IDLE cycle.
- wb_data_o holds its last value when wb_valid_o = 0.

Decomposition:
- Shared package fpu_pkg:
  - typedef enum logic [2:0] fpu_ctrl_state_e {IDLE, START, WAIT, WB, DRAIN};
  - 4-bit FPU opcode constants;
  - rounding-mode constants RNE/RTZ/RDN/RUP/RMM/DYN.
- One sub-module, fpu_timeout_cnt: clear/enable counter with a terminal-count flag, parameterised by CNT_W and TIMEOUT_CYCLES.

Test Plan:
- Issue op=4'h1, rs1=32'h3F800000, rs2=32'h40000000, rd=5; FPU model returns 32'h40400000 after 8 cycles -> start pulse 1 cycle; stall_o high 10 cycles; wb_valid_o=1, wb_rd_o=5, wb_data_o=32'h40400000 once.
- Two back-to-back issues (rd=3, rd=4) -> second start_o only after the first WB; two writebacks in order.
- Flush in the 3rd WAIT cycle -> DRAIN; stall_o=0 while issue_valid_i=0; done pulse discarded; no wb_valid_o; returns to IDLE.
- FPU model never raises done, TIMEOUT_CYCLES=16 -> timeout_err_o pulses 16 cycles after start; stall_o released.
- fpu_done_i and flush_i in the same WAIT cycle -> no writeback; IDLE on the next cycle.
- rst_n low during WAIT -> all outputs 0 asynchronously; new issue after release works normally.
